input_port_ctrl: RTL and testbench



---
 rtl/noc_pkg.sv | 30 +++
 rtl/xy_route_compute.sv | 39 +++
 rtl/input_port_ctrl.sv | 116 +++++++++++
 tb/tb_input_port_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, output port indices and helpers.
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_SINGLE = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_BODY   = 2'b10,
    FLIT_TAIL   = 2'b11
  } flit_type_t;

  localparam int unsigned PORT_LOCAL = 0;
  localparam int unsigned PORT_NORTH = 1;
  localparam int unsigned PORT_EAST  = 2;
  localparam int unsigned PORT_SOUTH = 3;
  localparam int unsigned PORT_WEST  = 4;
  localparam int unsigned NUM_PORTS  = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ipc_state_t;

  // One-hot request vector selecting a single output port.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input int unsigned idx);
    logic [NUM_PORTS-1:0] one;
    one = {{(NUM_PORTS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/xy_route_compute.sv
// Dimension-ordered (X first, then Y) route computation for a head flit.
import noc_pkg::*;

module xy_route_compute #(
  parameter int DATA_WIDTH  = 32,
  parameter int COORD_WIDTH = 2
) (
  input  logic [DATA_WIDTH-1:0]  flit,
  input  logic [COORD_WIDTH-1:0] x_coord,
  input  logic [COORD_WIDTH-1:0] y_coord,
  output logic [NUM_PORTS-1:0]   port
);

  logic [COORD_WIDTH-1:0] dest_x;
  logic [COORD_WIDTH-1:0] dest_y;
  logic                   unused_flit_bits;

  assign dest_x = flit[DATA_WIDTH-3 -: COORD_WIDTH];
  assign dest_y = flit[DATA_WIDTH-3-COORD_WIDTH -: COORD_WIDTH];
  // Payload bits play no part in routing.
  assign unused_flit_bits = ^flit;

  // Resolve X offset first; Y is only considered once X matches.
  always_comb begin
    port = port_onehot(PORT_LOCAL);
    if (dest_x > x_coord) begin
      port = port_onehot(PORT_EAST);
    end else if (dest_x < x_coord) begin
      port = port_onehot(PORT_WEST);
    end else if (dest_y > y_coord) begin
      port = port_onehot(PORT_NORTH);
    end else if (dest_y < y_coord) begin
      port = port_onehot(PORT_SOUTH);
    end else begin
      port = port_onehot(PORT_LOCAL);
    end
  end

endmodule

// File: rtl/input_port_ctrl.sv
// Router input-port controller: routes head flits, requests the allocator
// and streams the packet from the input FIFO into the crossbar.
import noc_pkg::*;

module input_port_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int COORD_WIDTH = 2,
  parameter int X_COORD     = 0,
  parameter int Y_COORD     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [4:0]            req,
  input  logic [4:0]            grant,
  output logic [DATA_WIDTH-1:0] out_flit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_drop
);

  localparam logic [COORD_WIDTH-1:0] MY_X = COORD_WIDTH'(X_COORD);
  localparam logic [COORD_WIDTH-1:0] MY_Y = COORD_WIDTH'(Y_COORD);

  ipc_state_t     state;
  ipc_state_t     next_state;
  logic [4:0]     next_req;
  logic [4:0]     route;
  logic           fired;        // at least one flit of this packet has left
  logic           next_fired;
  logic           drop;
  logic           granted;
  logic           fire;
  flit_type_t     ftype;

  assign ftype    = flit_type_t'(fifo_dout[DATA_WIDTH-1 -: 2]);
  assign out_flit = fifo_dout;

  xy_route_compute #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COORD_WIDTH (COORD_WIDTH)
  ) u_route (
    .flit    (fifo_dout),
    .x_coord (MY_X),
    .y_coord (MY_Y),
    .port    (route)
  );

  // Next-state, request and handshake decode for the packet FSM.
  always_comb begin
    next_state = state;
    next_req   = req;
    next_fired = fired;
    drop       = 1'b0;
    out_valid  = 1'b0;
    fire       = 1'b0;
    granted    = |(grant & req);
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if ((ftype == FLIT_HEAD) || (ftype == FLIT_SINGLE)) begin
            next_req   = route;
            next_state = ST_ACTIVE;
            next_fired = 1'b0;
          end else begin
            // Body/tail with no owning head: discard it.
            drop = 1'b1;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        out_valid = granted & ~fifo_empty;
        fire      = out_valid & out_ready;
        if (fire) begin
          // A single flit only terminates the packet when it is the first
          // flit; later head/single codes are streamed as body flits.
          if ((ftype == FLIT_TAIL) || ((ftype == FLIT_SINGLE) && !fired)) begin
            next_state = ST_IDLE;
            next_req   = 5'b00000;
            next_fired = 1'b0;
          end else begin
            next_fired = 1'b1;
          end
        end else begin
          next_state = ST_ACTIVE;
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_req   = 5'b00000;
        next_fired = 1'b0;
      end
    endcase
    fifo_rd_en = fire | drop;
  end

  // State, held request, packet position and the registered drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      req      <= 5'b00000;
      fired    <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      state    <= next_state;
      req      <= next_req;
      fired    <= next_fired;
      err_drop <= drop;
    end
  end

endmodule

// File: tb/tb_input_port_ctrl.sv
// Self-checking bench for input_port_ctrl with a packet-level reference model.
module tb_input_port_ctrl;

  localparam int DW = 32;
  localparam int CW = 2;
  localparam int RX = 1;
  localparam int RY = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic [4:0]    req;
  logic [4:0]    grant;
  logic [DW-1:0] out_flit;
  logic          out_valid;
  logic          out_ready;
  logic          err_drop;

  always #5 clk = ~clk;

  input_port_ctrl #(
    .DATA_WIDTH  (DW),
    .COORD_WIDTH (CW),
    .X_COORD     (RX),
    .Y_COORD     (RY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .req        (req),
    .grant      (grant),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_drop   (err_drop)
  );

  logic [DW-1:0] q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            n_fire = 0;
  int            n_drop_seen = 0;
  int            cyc = 0;
  int            fire_cycles[$];

  // Reference model: the request of the packet in progress (0 = none),
  // whether that packet has already sent a flit, and the pending drop pulse.
  logic [4:0]    m_req = 5'b00000;
  bit            m_fired = 1'b0;
  bit            m_err = 1'b0;

  function automatic logic [4:0] xy_ref(input int dx, input int dy);
    if (dx > RX) return 5'b00100;
    if (dx < RX) return 5'b10000;
    if (dy > RY) return 5'b00010;
    if (dy < RY) return 5'b01000;
    return 5'b00001;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int dx, input int dy);
    logic [DW-1:0] f;
    f = $urandom;
    f[DW-1:DW-2] = t;
    f[DW-3 -: CW] = dx[CW-1:0];
    f[DW-3-CW -: CW] = dy[CW-1:0];
    return f;
  endfunction

  task automatic push_pkt(input int dx, input int dy, input int len);
    if (len <= 1) begin
      q.push_back(mk(2'b00, dx, dy));
    end else begin
      q.push_back(mk(2'b01, dx, dy));
      for (int i = 0; i < len - 2; i++) q.push_back(mk(2'b10, dx, dy));
      q.push_back(mk(2'b11, dx, dy));
    end
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_dout  = fifo_empty ? DW'($urandom) : q[0];
  endtask

  // One clock cycle: apply inputs, check against the model, advance.
  task automatic step(input logic [4:0] g, input logic rdy);
    logic [1:0] t;
    bit e_valid, e_drop, e_rd, empty;
    grant = g;
    out_ready = rdy;
    drive_fifo();
    empty = fifo_empty;
    #1;
    t = fifo_dout[DW-1:DW-2];
    e_valid = (m_req != 5'b00000) && ((g & m_req) != 5'b00000) && !empty;
    e_drop  = (m_req == 5'b00000) && !empty && t[1];
    e_rd    = (e_valid && rdy) || e_drop;
    check("req", DW'(req), DW'(m_req));
    check("out_valid", DW'(out_valid), DW'(e_valid));
    check("fifo_rd_en", DW'(fifo_rd_en), DW'(e_rd));
    check("err_drop", DW'(err_drop), DW'(m_err));
    if (e_valid) check("out_flit", out_flit, q[0]);
    if (err_drop) n_drop_seen++;
    if (e_valid && rdy) begin
      n_fire++;
      fire_cycles.push_back(cyc);
    end
    m_err = e_drop;
    if ((m_req == 5'b00000) && !empty && !t[1]) begin
      m_req = xy_ref(int'(fifo_dout[DW-3 -: CW]), int'(fifo_dout[DW-3-CW -: CW]));
      m_fired = 1'b0;
    end else if (e_valid && rdy) begin
      if ((t == 2'b11) || ((t == 2'b00) && !m_fired)) m_req = 5'b00000;
      else m_fired = 1'b1;
    end
    @(posedge clk);
    if (fifo_rd_en && (q.size() > 0)) void'(q.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && ((q.size() != 0) || (m_req != 5'b00000) || m_err); i++)
      step(5'b11111, 1'b1);
    check(tag, DW'(q.size()), DW'(0));
  endtask

  initial begin
    rst = 1'b1;
    grant = 5'b00000;
    out_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout = '0;
    #2;
    check("rst_req", DW'(req), DW'(0));
    check("rst_valid", DW'(out_valid), DW'(0));
    check("rst_err", DW'(err_drop), DW'(0));
    check("rst_rd", DW'(fifo_rd_en), DW'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // East route from (1,1) to (3,1): head, body, tail
    push_pkt(3, 1, 3);
    n_fire = 0;
    for (int i = 0; i < 5; i++) step(5'b00100, 1'b1);
    check("east_fires", DW'(n_fire), DW'(3));

    // Local single flit
    push_pkt(1, 1, 1);
    n_fire = 0;
    for (int i = 0; i < 3; i++) step(5'b00001, 1'b1);
    check("local_fires", DW'(n_fire), DW'(1));

    // Backpressure, then grant loss, mid-packet (West)
    push_pkt(0, 2, 5);
    step(5'b10000, 1'b1);
    step(5'b10000, 1'b1);
    for (int i = 0; i < 3; i++) step(5'b10000, 1'b0);
    for (int i = 0; i < 2; i++) step(5'b00000, 1'b1);
    check("stall_left", DW'(q.size()), DW'(4));
    drain("stall_drain");

    // Orphan body followed by a normal packet
    q.push_back(mk(2'b10, 0, 0));
    push_pkt(2, 3, 2);
    n_drop_seen = 0;
    drain("orphan_drain");
    check("orphan_pulses", DW'(n_drop_seen), DW'(1));

    // Reset after the head has fired
    push_pkt(3, 0, 3);
    step(5'b11111, 1'b1);
    step(5'b11111, 1'b1);
    drive_fifo();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_req", DW'(req), DW'(0));
    check("midrst_valid", DW'(out_valid), DW'(0));
    @(negedge clk);
    rst = 1'b0;
    m_req = 5'b00000;
    m_fired = 1'b0;
    m_err = 1'b0;
    n_drop_seen = 0;
    drain("midrst_drain");
    check("midrst_pulses", DW'(n_drop_seen), DW'(2));

    // Back-to-back North then South, 2 flits each
    push_pkt(1, 3, 2);
    push_pkt(1, 0, 2);
    fire_cycles.delete();
    drain("b2b_drain");
    check("b2b_fires", DW'(fire_cycles.size()), DW'(4));
    if (fire_cycles.size() == 4)
      check("b2b_gap", DW'(fire_cycles[2] - fire_cycles[1]), DW'(2));

    // Head and single codes inside a packet stream as body flits
    q.push_back(mk(2'b01, 3, 3));
    q.push_back(mk(2'b01, 0, 0));
    q.push_back(mk(2'b00, 0, 0));
    q.push_back(mk(2'b11, 0, 0));
    n_fire = 0;
    drain("embed_drain");
    check("embed_fires", DW'(n_fire), DW'(4));

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if ((q.size() < 3) && ($urandom_range(0, 2) == 0)) begin
        if ($urandom_range(0, 7) == 0)
          q.push_back(mk(2'($urandom_range(2, 3)), 0, 0));
        else
          push_pkt($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4));
      end
      step(($urandom_range(0, 3) != 0) ? 5'b11111 : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 4) != 0));
    end
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
